rx_verify_ctrl: RTL
===================

# rx_verify_ctrl

Sequencing controller for the Keccak-based packet verifier. It accepts a 2112-bit packet (512-bit message followed by a 1600-bit expected hash) as a 64-bit word stream and launches the Keccak hash core on the message. It then compares the core's 1600-bit result against the expected hash and presents the 80-bit ASCII verdict ("MSGCORRECT" or "M SGWRONG ") on a valid/ready output. It sits between the link deserialiser and the transmit path and owns the hash core exclusively.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64, max cycles waited for hash_done (used only with RX_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- s_valid  in  1  input word valid
- s_ready  out  1  input word accepted when s_valid & s_ready
- s_data  in  64  packet word; word 0 is packet bits [2111:2048]
- s_last  in  1  marks final word of packet
- s_bytenum  in  3  message byte count code, sampled on word 0 only
- hash_start  out  1  one-cycle start pulse to hash core
- hash_msg  out  512  message to core (buffer[2111:1600]), stable from start to done
- hash_bytenum  out  3  registered s_bytenum
- hash_done  in  1  core result valid (single-cycle pulse)
- hash_out  in  1600  core result, valid when hash_done=1
- txout  out  80  verdict text
- txout_valid  out  1  verdict valid
- txout_ready  in  1  downstream accepts verdict
- err_framing  out  1  qualifies current verdict: packet length error
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, LOAD, DRAIN, START, WAIT, CMP, REPORT.
- IDLE/LOAD: s_ready=1. Each accepted beat shifts the 2112-bit buffer left by 64 bits, inserting s_data in bits [63:0]; word counter wcnt (6-bit) increments. First accepted beat moves IDLE->LOAD and latches s_bytenum.
- Beat with s_last and wcnt==32 (33rd word): go to START.
- Beat with s_last and wcnt<32: framing error; go to REPORT with verdict WRONG, err_framing=1.
- Beat at wcnt==32 without s_last: go to DRAIN (s_ready=1) and discard beats until s_last is accepted, then REPORT with WRONG, err_framing=1.
- START: hash_start=1 for exactly one cycle, s_ready=0; go to WAIT.
- WAIT: s_ready=0; on hash_done=1, register match = (hash_out == buffer[1599:0]); go to CMP. hash_done outside WAIT is ignored.
- CMP: load txout = 80'h4d5347434f5252454354 ("MSGCORRECT") if match, else 80'h4d20534757524f4e4720 ("M SGWRONG "); err_framing=0; go to REPORT.
- REPORT: txout_valid=1; txout and err_framing held stable until txout_valid & txout_ready, then IDLE with txout_valid=0. s_ready=0 throughout.
- Reset (any state, including mid-packet or mid-hash): all state cleared; next hash_done is ignored unless a new START has been issued.

## Timing
- Reset values: s_ready=0 during the reset cycle, 1 the cycle after; hash_start=0, hash_bytenum=0, txout=0, txout_valid=0, err_framing=0, busy=0; buffer and wcnt cleared.
- hash_start is asserted the cycle after the s_last beat is accepted.
- txout_valid is asserted 2 cycles after the hash_done cycle (WAIT->CMP->REPORT).
- Framing-error verdict is asserted the cycle after the offending s_last beat.
- Throughput: one packet in flight; the next packet's first word is accepted the cycle after the verdict handshake.
- hash_msg is a direct view of the buffer; the buffer does not change outside IDLE/LOAD/DRAIN. DRAIN does not shift.

## Configuration
- RX_TIMEOUT_EN defined: cycle counter runs in WAIT; if hash_done has not arrived after TIMEOUT_CYCLES cycles, go to REPORT with WRONG and err_framing=0, then IDLE. A late hash_done is then ignored.
- Undefined: WAIT blocks indefinitely until hash_done; no counter is synthesised.

## Test plan
- 33 beats, s_last on beat 33, hash core model returns hash_out equal to beats 9–33 -> hash_start 1 cycle after last beat; txout=80'h4d5347434f5252454354, err_framing=0, 2 cycles after hash_done.
- Same packet with hash_out bit 0 flipped -> txout=80'h4d20534757524f4e4720, err_framing=0.
- s_last on beat 5 -> no hash_start; next cycle txout_valid=1, WRONG, err_framing=1; input accepted again after handshake.
- 40 beats, s_last on beat 40 -> beats 34–40 discarded, no hash_start; WRONG with err_framing=1 after beat 40.
- txout_ready held low for 10 cycles in REPORT -> txout stable, s_ready=0; single handshake, then back to IDLE.
- reset asserted in WAIT, then stray hash_done -> no verdict. With RX_TIMEOUT_EN and TIMEOUT_CYCLES=64, no hash_done -> WRONG after 64 WAIT cycles.

Source files
------------

// File: rtl/rx_verify_ctrl.sv
// rx_verify_ctrl: buffers a 33-word packet, launches the Keccak core on the message and reports the hash verdict.
// Optional WAIT timeout enabled by defining RX_TIMEOUT_EN.
module rx_verify_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [63:0]   s_data,
  input  logic          s_last,
  input  logic [2:0]    s_bytenum,
  output logic          hash_start,
  output logic [511:0]  hash_msg,
  output logic [2:0]    hash_bytenum,
  input  logic          hash_done,
  input  logic [1599:0] hash_out,
  output logic [79:0]   txout,
  output logic          txout_valid,
  input  logic          txout_ready,
  output logic          err_framing,
  output logic          busy
);
  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, START, WAIT, CMP, REPORT} state_t;
  localparam logic [79:0] MSG_OK  = 80'h4d5347434f5252454354;
  localparam logic [79:0] MSG_BAD = 80'h4d20534757524f4e4720;
  state_t        state_q;
  logic [2111:0] pkt_q;
  logic [5:0]    wcnt_q;
  logic          match_q;
  logic          hash_start_q;
  logic [2:0]    bytenum_q;
  logic [79:0]   txout_q;
  logic          txout_valid_q;
  logic          err_q;
  logic          take;
`ifdef RX_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] tcnt_q;
`endif
  // s_ready is gated by reset so it reads 0 during the reset cycle itself
  assign s_ready      = ~reset & (state_q == IDLE | state_q == LOAD | state_q == DRAIN);
  assign take         = s_valid & s_ready;
  assign hash_start   = hash_start_q;
  assign hash_msg     = pkt_q[2111:1600];
  assign hash_bytenum = bytenum_q;
  assign txout        = txout_q;
  assign txout_valid  = txout_valid_q;
  assign err_framing  = err_q;
  assign busy         = state_q != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pkt_q         <= '0;
      wcnt_q        <= '0;
      match_q       <= 1'b0;
      hash_start_q  <= 1'b0;
      bytenum_q     <= '0;
      txout_q       <= '0;
      txout_valid_q <= 1'b0;
      err_q         <= 1'b0;
`ifdef RX_TIMEOUT_EN
      tcnt_q        <= '0;
`endif
    end else begin
      hash_start_q <= 1'b0;
      case (state_q)
        IDLE, LOAD: if (take) begin
          pkt_q  <= {pkt_q[2047:0], s_data};
          wcnt_q <= wcnt_q + 6'd1;
          if (state_q == IDLE) bytenum_q <= s_bytenum;
          if (wcnt_q == 6'd32) begin
            state_q      <= s_last ? START : DRAIN;
            hash_start_q <= s_last;
          end else if (s_last) begin
            state_q <= REPORT; txout_q <= MSG_BAD; err_q <= 1'b1; txout_valid_q <= 1'b1;
          end else begin
            state_q <= LOAD;
          end
        end
        DRAIN: if (take && s_last) begin
          state_q <= REPORT; txout_q <= MSG_BAD; err_q <= 1'b1; txout_valid_q <= 1'b1;
        end
        START: begin
          state_q <= WAIT;
`ifdef RX_TIMEOUT_EN
          tcnt_q  <= '0;
`endif
        end
        WAIT: if (hash_done) begin
          match_q <= hash_out == pkt_q[1599:0];
          state_q <= CMP;
        end
`ifdef RX_TIMEOUT_EN
        else if (tcnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
          state_q <= REPORT; txout_q <= MSG_BAD; err_q <= 1'b0; txout_valid_q <= 1'b1;
        end else begin
          tcnt_q <= tcnt_q + 1'b1;
        end
`endif
        CMP: begin
          txout_q       <= match_q ? MSG_OK : MSG_BAD;
          err_q         <= 1'b0;
          txout_valid_q <= 1'b1;
          state_q       <= REPORT;
        end
        REPORT: if (txout_ready) begin
          txout_valid_q <= 1'b0;
          wcnt_q        <= '0;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
